// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port data memory: fetch vs load/store,
// round-robin with an optional data lock, read data routed back by requester id.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic                  d_lock,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // Requester ids: 0 = fetch, 1 = data.
  logic last_q;
  logic lock_own_q;
  logic rsp_v_q;
  logic rsp_id_q;

  logic sel_i;
  logic sel_d;
  logic granted;
  logic g_we;

  // Grant decision; nothing is granted while reset is held.
  always_comb begin
    sel_i = 1'b0;
    sel_d = 1'b0;
    if (rst) begin
      if (i_req && d_req) begin
        if ((lock_own_q && d_lock) || !last_q) begin
          sel_d = 1'b1;
        end else begin
          sel_i = 1'b1;
        end
      end else begin
        sel_i = i_req;
        sel_d = d_req;
      end
    end
  end

  assign granted = sel_i | sel_d;
  assign g_we    = sel_d ? d_we : i_we;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (sel_d) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (sel_i) begin
      mem_addr  = i_addr;
      mem_wdata = i_wdata;
    end
  end

  assign i_gnt   = sel_i;
  assign d_gnt   = sel_d;
  assign mem_wen = granted & g_we;
  assign mem_ren = granted & ~g_we;

  assign i_rvalid = rsp_v_q & ~rsp_id_q;
  assign d_rvalid = rsp_v_q & rsp_id_q;
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q     <= 1'b1;
      lock_own_q <= 1'b0;
      rsp_v_q    <= 1'b0;
      rsp_id_q   <= 1'b0;
    end else if (granted) begin
      last_q     <= sel_d;
      lock_own_q <= sel_d & d_lock;
      rsp_v_q    <= ~g_we;
      rsp_id_q   <= sel_d;
    end else begin
      rsp_v_q <= 1'b0;
      if (!d_lock) begin
        lock_own_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port data memory between the instruction-fetch requester and the load/store requester of the CPU. It grants at most one access per cycle and resolves conflicts round-robin, with an optional lock for back-to-back data accesses. It returns read data to the requester that issued the read. It sits between the `fetch`/`write` stages and `memory`, replacing their direct connections.

## Interface
- `ADDR_WIDTH`, 5, memory word-address width
- `DATA_WIDTH`, 32, memory data width

- `clk` in 1 — single clock, rising edge
- `rst` in 1 — asynchronous, active-low reset
- `i_req` in 1 — fetch requests an access; addr/we/wdata held stable until granted
- `i_we` in 1 — fetch access is a write (normally 0)
- `i_addr` in ADDR_WIDTH — fetch address
- `i_wdata` in DATA_WIDTH — fetch write data
- `i_gnt` out 1 — fetch access issued to memory this cycle
- `i_rvalid` out 1 — fetch read data valid
- `i_rdata` out DATA_WIDTH — fetch read data
- `d_req`, `d_we`, `d_addr`, `d_wdata`, `d_gnt`, `d_rvalid`, `d_rdata` — same as the `i_` ports, for the load/store requester
- `d_lock` in 1 — data requester keeps priority while asserted
- `mem_addr` out ADDR_WIDTH — memory address
- `mem_wdata` out DATA_WIDTH — memory write data
- `mem_wen` out 1 — memory write strobe
- `mem_ren` out 1 — memory read strobe
- `mem_rdata` in DATA_WIDTH — memory read data, valid the cycle after `mem_ren`

## Operation
- **State:**
  - `last` (0 = fetch, 1 = data), the requester granted most recently
  - `lock_own`, set when a data grant occurs with `d_lock`=1
  - response pipeline `rsp_v`/`rsp_id` (1 deep)
- **Grant (combinational, same cycle as request):**
  - Only one requester: grant it.
  - Both requesting, `lock_own`=1 and `d_lock`=1: grant data.
  - Both requesting, otherwise: grant the requester ≠ `last`.
  - Neither requesting: no grant.
  - `i_gnt` and `d_gnt` are never both 1.
- **Memory drive:**
  - While a grant is active, mem_addr/mem_wdata come from the granted requester, `mem_wen` = granted we, `mem_ren` = !granted we.
  - With no grant, all `mem_*` outputs are 0.
- **Update on clock edge with a grant:**
  - `last` ← granted id.
  - `lock_own` ← (granted id = data) & `d_lock`.
  - `rsp_v` ← read granted; `rsp_id` ← granted id.
- **Update on clock edge without a grant:**
  - `rsp_v` ← 0.
  - `lock_own` is cleared if `d_lock`=0.
- **Response:**
  - `x_rvalid` = `rsp_v` & (`rsp_id` = x).
  - `x_rdata` = `mem_rdata` when that requester's rvalid is 1, else 0.
  - Writes produce no rvalid.
- **Lock release:** deasserting `d_lock` returns to round-robin on the same cycle. If `lock_own`=1 but `d_lock`=0, arbitration is plain round-robin.
- **Starvation bound:** without a held lock, a pending request is granted within 2 cycles.

## Timing
- Throughput: one access per cycle, back-to-back grants allowed, including a read followed by a read from the other requester.
- Latency:
  - request → grant: 0 cycles
  - read grant → rvalid: 1 cycle
  - write completes at the grant edge
- **Reset (`rst`=0, asynchronous):**
  - `last`=1, so fetch wins the first conflict.
  - `lock_own`=0, `rsp_v`=0, `rsp_id`=0.
  - All gnt, rvalid, rdata and `mem_*` outputs are forced to 0 while `rst`=0, regardless of requests.
- Reset asserted in the cycle after a read grant drops that response: no rvalid after reset release.
- First grant is possible in the first cycle `rst`=1.
- Requesters must not change addr/we/wdata while req=1 and gnt=0. The arbiter does not check this.

## Test plan
- **Reset:** `rst`=0 with both req=1 → all outputs 0. Release → `i_gnt`=1 first (conflict goes to fetch).
- **Conflict alternation:** both req=1 continuously, both reads → `i_gnt`,`d_gnt` alternate I,D,I,D. rvalid follows each grant by 1 cycle with `mem_rdata` routed to the matching requester (e.g. addr 3 → 0xDEADBEEF on `i_rdata`).
- **Write:** `d_req`=1, `d_we`=1, `d_addr`=7, `d_wdata`=0x12345678, no fetch request → `mem_wen`=1, `mem_addr`=7, `mem_wdata`=0x12345678, `mem_ren`=0, no `d_rvalid` on the next cycle.
- **Lock:** both req=1, `d_lock`=1 from the first data grant → `d_gnt` for 4 consecutive cycles, `i_gnt`=0. Drop `d_lock` → `i_gnt`=1 that same cycle.
- **Idle:** no requests for 3 cycles → `mem_*`=0, no rvalid, `last` unchanged (next conflict goes to the requester not granted last).
- **Mid-operation reset:** read granted, `rst` pulsed low before the next edge → no rvalid after release, `i_rdata`=`d_rdata`=0.
